// File: rtl/beep_pkg.sv
// Shared definitions for the melody sequencer: state encoding, tone codes,
// tone frequency table and the period helper used to build the ARR table.
package beep_pkg;

   localparam int TONE_W = 4;
   localparam int DUR_W  = 8;

   // Sequencer state encoding
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_PLAY = 3'd2;
   localparam logic [2:0] S_GAP  = 3'd3;
   localparam logic [2:0] S_FIN  = 3'd4;

   // Tone codes; 0 and 15 are rests
   localparam logic [3:0] T_REST = 4'd0;
   localparam logic [3:0] T_C4   = 4'd1;
   localparam logic [3:0] T_D4   = 4'd2;
   localparam logic [3:0] T_E4   = 4'd3;
   localparam logic [3:0] T_F4   = 4'd4;
   localparam logic [3:0] T_G4   = 4'd5;
   localparam logic [3:0] T_A4   = 4'd6;
   localparam logic [3:0] T_B4   = 4'd7;
   localparam logic [3:0] T_C5   = 4'd8;

   // Tone frequencies in Hz, indexed by tone code (0 = rest)
   localparam int unsigned TONE_FREQ [16] = '{
      0, 262, 294, 330, 349, 392, 440, 494,
      524, 588, 660, 698, 784, 880, 988, 0
   };

   // PWM period in clocks for a tone; rests get the minimum legal period
   function automatic logic [31:0] tone_arr(input logic [3:0] code,
                                            input int unsigned clk_freq);
      int unsigned f;
      int unsigned p;
      f = TONE_FREQ[code];
      if (f == 0) return 32'd2;
      p = clk_freq / f;
      return (p < 2) ? 32'd2 : p;
   endfunction

endpackage

// File: rtl/beep_melody_rom.sv
// Song storage: combinational note list, {tone, dur} per address.
// An entry with dur == 0 marks the end of the song.
module beep_melody_rom
   import beep_pkg::*;
#(
   parameter int SONG = 0,
   parameter int AW   = 5
)(
   input  logic [AW-1:0]     addr,
   output logic [TONE_W-1:0] tone,
   output logic [DUR_W-1:0]  dur
);

   // Song table lookup; unlisted addresses read as end markers
   always_comb begin
      tone = T_REST;
      dur  = '0;
      if (SONG == 1) begin
         case (int'(addr))
            0:       begin tone = T_A4;   dur = 8'd2; end
            1:       begin tone = T_C4;   dur = 8'd1; end
            default: begin tone = T_REST; dur = 8'd0; end
         endcase
      end else if (SONG == 2) begin
         case (int'(addr))
            0:       begin tone = T_A4;   dur = 8'd2; end
            1:       begin tone = T_REST; dur = 8'd3; end
            2:       begin tone = T_C5;   dur = 8'd1; end
            3:       begin tone = T_E4;   dur = 8'd1; end
            default: begin tone = T_REST; dur = 8'd0; end
         endcase
      end else begin
         case (int'(addr))
            0:       begin tone = T_C4;   dur = 8'd2; end
            1:       begin tone = T_C4;   dur = 8'd2; end
            2:       begin tone = T_G4;   dur = 8'd2; end
            3:       begin tone = T_G4;   dur = 8'd2; end
            4:       begin tone = T_A4;   dur = 8'd2; end
            5:       begin tone = T_A4;   dur = 8'd2; end
            6:       begin tone = T_G4;   dur = 8'd4; end
            7:       begin tone = T_F4;   dur = 8'd2; end
            8:       begin tone = T_F4;   dur = 8'd2; end
            9:       begin tone = T_E4;   dur = 8'd2; end
            10:      begin tone = T_E4;   dur = 8'd2; end
            11:      begin tone = T_D4;   dur = 8'd2; end
            12:      begin tone = T_D4;   dur = 8'd2; end
            13:      begin tone = T_C4;   dur = 8'd4; end
            14:      begin tone = T_B4;   dur = 8'd0; end
            default: begin tone = T_REST; dur = 8'd0; end
         endcase
      end
   end

endmodule

// File: rtl/beep_melody_seq.sv
// Melody sequencer driving the PWM beeper: walks the note ROM, holds each
// note for dur units, inserts a silent gap, supports loop/stop/volume.
module beep_melody_seq
   import beep_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned UNIT_CYC = 3_125_000,
   parameter int unsigned GAP_CYC  = 250_000,
   parameter int          NOTE_NUM = 32,
   parameter int          SONG     = 0,
   parameter int          IDX_W    = $clog2(NOTE_NUM)
)(
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             start,
   input  logic             stop,
   input  logic             loop_en,
   input  logic [1:0]       vol,
   output logic             pwm_gen_en,
   output logic [31:0]      counter_arr,
   output logic [31:0]      counter_ccr,
   output logic             busy,
   output logic [IDX_W-1:0] note_idx,
   output logic             done
);

   logic [2:0]        state;
   logic [31:0]       cyc_cnt;   // unit cycles during PLAY, gap cycles during GAP
   logic [DUR_W-1:0]  unit_cnt;  // remaining duration units after the current one
   logic              rest_q;
   logic [TONE_W-1:0] rom_tone;
   logic [DUR_W-1:0]  rom_dur;
   logic [31:0]       arr_tab [16];
   logic [31:0]       ld_arr;
   logic              last_idx;

   beep_melody_rom #(.SONG(SONG), .AW(IDX_W)) u_rom (
      .addr (note_idx),
      .tone (rom_tone),
      .dur  (rom_dur)
   );

   // Periods are constant per tone, so the divide folds away at elaboration
   for (genvar g = 0; g < 16; g++) begin : g_arr
      assign arr_tab[g] = tone_arr(4'(g), CLK_FREQ);
   end

   assign ld_arr     = arr_tab[rom_tone];
   assign last_idx   = (note_idx == IDX_W'(NOTE_NUM - 1));
   assign busy       = (state != S_IDLE);
   assign done       = (state == S_FIN);
   assign pwm_gen_en = (state == S_PLAY) && !rest_q;

   // Sequencer FSM with nested unit/cycle counters; stop overrides everything
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state       <= S_IDLE;
         note_idx    <= '0;
         counter_arr <= '0;
         counter_ccr <= '0;
         cyc_cnt     <= '0;
         unit_cnt    <= '0;
         rest_q      <= 1'b0;
      end else if (stop && state != S_IDLE) begin
         state    <= S_IDLE;
         note_idx <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               state    <= S_LOAD;
               note_idx <= '0;
            end
            S_LOAD: begin
               if (rom_dur == '0) begin
                  if (loop_en) begin
                     note_idx <= '0;
                     state    <= S_LOAD;
                  end else begin
                     state <= S_FIN;
                  end
               end else begin
                  counter_arr <= ld_arr;
                  counter_ccr <= ld_arr >> ({1'b0, vol} + 3'd1);
                  rest_q      <= (rom_tone == 4'd0) || (rom_tone == 4'd15);
                  cyc_cnt     <= 32'(UNIT_CYC - 1);
                  unit_cnt    <= rom_dur - 1'b1;
                  state       <= S_PLAY;
               end
            end
            S_PLAY: begin
               if (cyc_cnt == '0) begin
                  if (unit_cnt == '0) begin
                     cyc_cnt <= 32'(GAP_CYC - 1);
                     state   <= S_GAP;
                  end else begin
                     unit_cnt <= unit_cnt - 1'b1;
                     cyc_cnt  <= 32'(UNIT_CYC - 1);
                  end
               end else begin
                  cyc_cnt <= cyc_cnt - 1'b1;
               end
            end
            S_GAP: begin
               if (cyc_cnt == '0) begin
                  if (!last_idx) begin
                     note_idx <= note_idx + 1'b1;
                     state    <= S_LOAD;
                  end else if (loop_en) begin
                     note_idx <= '0;
                     state    <= S_LOAD;
                  end else begin
                     state <= S_FIN;
                  end
               end else begin
                  cyc_cnt <= cyc_cnt - 1'b1;
               end
            end
            S_FIN: begin
               note_idx <= '0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_beep_melody_seq.sv
// Bench for beep_melody_seq: two instances (short song with end marker,
// 4-deep song with a rest) compared cycle by cycle against a note timeline.
module tb_beep_melody_seq;

   typedef struct packed {
      logic        pwm;
      logic [31:0] arr;
      logic [31:0] ccr;
      logic        busy;
      logic [7:0]  idx;
      logic        done;
   } obs_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       start_a = 1'b0, start_b = 1'b0, stop = 1'b0, loop_en = 1'b0;
   logic [1:0] vol = 2'd0;

   logic        pwm_a, busy_a, done_a, pwm_b, busy_b, done_b;
   logic [31:0] arr_a, ccr_a, arr_b, ccr_b;
   logic [4:0]  idx_a;
   logic [1:0]  idx_b;

   beep_melody_seq #(.CLK_FREQ(50_000_000), .UNIT_CYC(4), .GAP_CYC(2),
                     .NOTE_NUM(32), .SONG(1)) dut_a (
      .sys_clk(clk), .sys_rst(rst), .start(start_a), .stop(stop),
      .loop_en(loop_en), .vol(vol), .pwm_gen_en(pwm_a), .counter_arr(arr_a),
      .counter_ccr(ccr_a), .busy(busy_a), .note_idx(idx_a), .done(done_a));

   beep_melody_seq #(.CLK_FREQ(50_000_000), .UNIT_CYC(4), .GAP_CYC(2),
                     .NOTE_NUM(4), .SONG(2)) dut_b (
      .sys_clk(clk), .sys_rst(rst), .start(start_b), .stop(stop),
      .loop_en(loop_en), .vol(vol), .pwm_gen_en(pwm_b), .counter_arr(arr_b),
      .counter_ccr(ccr_b), .busy(busy_b), .note_idx(idx_b), .done(done_b));

   int   sel = 0;
   obs_t obs;
   always_comb begin
      obs = '0;
      if (sel == 0) obs = '{pwm_a, arr_a, ccr_a, busy_a, 8'(idx_a), done_a};
      else          obs = '{pwm_b, arr_b, ccr_b, busy_b, 8'(idx_b), done_b};
   end

   // Reference song data: index 0 -> dut_a, 1 -> dut_b
   int s_len  [2] = '{2, 4};
   int s_nn   [2] = '{32, 4};
   int s_tone [2][4] = '{'{6, 1, 0, 0}, '{6, 0, 8, 3}};
   int s_dur  [2][4] = '{'{2, 1, 0, 0}, '{2, 3, 1, 1}};
   localparam int UNIT = 4;
   localparam int GAP  = 2;

   int   held_arr [2] = '{0, 0};
   int   held_ccr [2] = '{0, 0};
   obs_t q[$];
   int   pass_cnt = 0;
   int   total = 0;

   function automatic int arrof(input int t);
      int base [7] = '{262, 294, 330, 349, 392, 440, 494};
      int f;
      if (t == 0 || t == 15) return 2;
      f = base[(t - 1) % 7] * ((t >= 8) ? 2 : 1);
      return 50_000_000 / f;
   endfunction

   function automatic obs_t mk(input int p, input int a, input int c,
                               input int b, input int i, input int d);
      obs_t o;
      o.pwm = p[0]; o.arr = a; o.ccr = c; o.busy = b[0]; o.idx = 8'(i); o.done = d[0];
      return o;
   endfunction

   // Flat per-cycle timeline of a playback starting the cycle after start
   task automatic build(input int s, input int v, input int lp, input int cap);
      int idx, ca, cc, t, d;
      q.delete();
      idx = 0; ca = held_arr[s]; cc = held_ccr[s];
      while (q.size() < cap) begin
         t = (idx < s_len[s]) ? s_tone[s][idx] : 0;
         d = (idx < s_len[s]) ? s_dur[s][idx] : 0;
         q.push_back(mk(0, ca, cc, 1, idx, 0));
         if (d == 0) begin
            if (lp != 0) begin idx = 0; continue; end
            q.push_back(mk(0, ca, cc, 1, idx, 1));
            break;
         end
         ca = arrof(t);
         cc = ca >> (v + 1);
         for (int k = 0; k < d * UNIT; k++)
            q.push_back(mk((t != 0 && t != 15) ? 1 : 0, ca, cc, 1, idx, 0));
         for (int k = 0; k < GAP; k++) q.push_back(mk(0, ca, cc, 1, idx, 0));
         if (idx == s_nn[s] - 1) begin
            if (lp != 0) begin idx = 0; continue; end
            q.push_back(mk(0, ca, cc, 1, idx, 1));
            break;
         end
         idx++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input obs_t exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic drive_start(input int s, input logic v);
      if (s == 0) start_a = v; else start_b = v;
   endtask

   // mode: 0 stop, 1 stop+start together, 2 reset with start high
   task automatic run(input string name, input int s, input int v, input int lp,
                      input int cap, input int stop_at, input int mode, input int poke);
      int n;
      sel = s; vol = 2'(v); loop_en = lp[0];
      build(s, v, lp, cap);
      n = (stop_at < 0) ? q.size() : ((stop_at >= q.size()) ? q.size() - 1 : stop_at);
      drive_start(s, 1'b1); tick(); drive_start(s, 1'b0);
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_cyc%0d", name, i), q[i]);
         if (i == poke) drive_start(s, 1'b1);
         tick();
         drive_start(s, 1'b0);
      end
      if (stop_at >= 0) begin
         check($sformatf("%s_cyc%0d", name, n), q[n]);
         if (mode == 2) begin rst = 1'b1; drive_start(s, 1'b1); end
         else begin stop = 1'b1; if (mode == 1) drive_start(s, 1'b1); end
         tick();
         rst = 1'b0; stop = 1'b0; drive_start(s, 1'b0);
         if (mode == 2) begin
            held_arr = '{0, 0}; held_ccr = '{0, 0};
         end else begin
            held_arr[s] = int'(q[n].arr); held_ccr[s] = int'(q[n].ccr);
         end
      end else begin
         held_arr[s] = int'(q[q.size() - 1].arr);
         held_ccr[s] = int'(q[q.size() - 1].ccr);
      end
      check({name, "_idle0"}, mk(0, held_arr[s], held_ccr[s], 0, 0, 0));
      tick();
      check({name, "_idle1"}, mk(0, held_arr[s], held_ccr[s], 0, 0, 0));
   endtask

   initial begin
      int v;
      tick(); tick();
      sel = 0; check("reset_a", mk(0, 0, 0, 0, 0, 0));
      sel = 1; check("reset_b", mk(0, 0, 0, 0, 0, 0));
      rst = 1'b0;
      tick();

      // Two-note song, full volume then lowest volume
      run("song_v0", 0, 0, 0, 1000, -1, 0, -1);
      run("song_v3", 0, 3, 0, 1000, -1, 0, -1);
      // Looped playback over ~3 passes, then stop
      run("loop", 0, int'($urandom_range(3)), 1, 200, 57, 0, -1);
      // Rest entry and end by reaching the last list index
      run("rest", 1, int'($urandom_range(3)), 0, 1000, -1, 0, -1);
      run("rest_loop", 1, int'($urandom_range(3)), 1, 200, 90, 0, -1);
      // Stop in the 5th PLAY cycle
      run("stop5", 0, 0, 0, 1000, 5, 0, -1);
      // start and stop together mid-song
      run("stopstart", 0, 1, 0, 1000, 12, 1, -1);
      // start pulses while busy are ignored
      run("poke", 0, 2, 0, 1000, -1, 0, 7);
      run("poke_b", 1, 0, 0, 1000, -1, 0, 20);
      // Random stop points and volumes
      for (int r = 0; r < 4; r++) begin
         v = int'($urandom_range(3));
         run($sformatf("rnd%0d", r), r & 1, v, 0, 1000,
             int'($urandom_range(40)), int'($urandom_range(1)), -1);
      end
      // Reset during PLAY with start high, then replay from note 0
      run("rst_play", 0, 0, 0, 1000, 3, 2, -1);
      run("after_rst", 0, 0, 0, 1000, -1, 0, -1);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
